// File: rtl/mips_alu_pkg.sv
// Shared ALU definitions: operation encodings for the add/subtract datapath.
package mips_alu_pkg;

    // Encoding 3 is unused and behaves as OP_ADD in the adder.
    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_ADDC = 2'd2
    } alu_op_t;

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: internal carries by lookahead, exports group G/P.
module cla_group4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       g,
    output logic       p
);
    logic [3:0] gb;
    logic [3:0] pb;
    logic [3:0] c;

    assign gb = a & b;
    assign pb = a ^ b;

    // Bit carries flattened to one AND-OR level each; G/P do not depend on cin.
    always_comb begin
        c[0] = cin;
        c[1] = gb[0] | (pb[0] & cin);
        c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin);
        c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
             | (pb[2] & pb[1] & pb[0] & cin);
        sum  = pb ^ c;
        g    = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
             | (pb[3] & pb[2] & pb[1] & gb[0]);
        p    = &pb;
    end

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead add/sub. Each stage resolves WIDTH/STAGES bits with
// two-level lookahead; stage carries ride in the pipeline registers.
module pipelined_cla_addsub
    import mips_alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             neg,
    output logic             zero
);
    localparam int NG  = WIDTH / 4;
    localparam int GPS = NG / STAGES;

    if (STAGES < 1 || WIDTH < 4 || (WIDTH % 4) != 0 || (NG % STAGES) != 0) begin : g_bad_params
        $error("pipelined_cla_addsub: WIDTH must be a multiple of 4 and WIDTH/4 divisible by STAGES");
    end

    logic                          adv;
    logic [STAGES:1]               vld_pipe;
    logic [WIDTH-1:0]              b_eff;
    logic                          c_eff;
    logic [STAGES-1:0]             stg_v, stg_c, stg_cout, q_c;
    logic [STAGES-1:0][WIDTH-1:0]  stg_a, stg_b, stg_sum, nxt_sum, q_a, q_b, q_sum;
    logic [NG-1:0][3:0]            grp_sum;
    logic [NG-1:0]                 grp_g, grp_p, grp_c;
    logic                          c_msb;
    logic                          q_ovf;

    // Carry into position n of a block of groups starting at base, all terms in parallel.
    function automatic logic la_carry(input logic [NG-1:0] gv, input logic [NG-1:0] pv,
                                      input int base, input int n, input logic ci);
        logic c, pp;
        pp = 1'b1;
        for (int i = 0; i < n; i++) pp &= pv[base+i];
        c = ci & pp;
        for (int i = 0; i < n; i++) begin
            pp = 1'b1;
            for (int m = i + 1; m < n; m++) pp &= pv[base+m];
            c |= gv[base+i] & pp;
        end
        return c;
    endfunction

    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];

    // Operand setup: subtract is a + ~b + 1; carry-in only honoured by ADDC.
    always_comb begin
        b_eff = (op == OP_SUB) ? ~b : b;
        c_eff = (op == OP_SUB) | ((op == OP_ADDC) & cin);
    end

    // Stage inputs: stage 0 from the ports, later stages from the previous register.
    always_comb begin
        stg_v[0]   = in_valid;
        stg_a[0]   = a;
        stg_b[0]   = b_eff;
        stg_c[0]   = c_eff;
        stg_sum[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            stg_v[k]   = vld_pipe[k];
            stg_a[k]   = q_a[k-1];
            stg_b[k]   = q_b[k-1];
            stg_c[k]   = q_c[k-1];
            stg_sum[k] = q_sum[k-1];
        end
    end

    for (genvar g = 0; g < NG; g++) begin : g_grp
        cla_group4 u_grp (
            .a   (stg_a[g/GPS][4*g +: 4]),
            .b   (stg_b[g/GPS][4*g +: 4]),
            .cin (grp_c[g]),
            .sum (grp_sum[g]),
            .g   (grp_g[g]),
            .p   (grp_p[g])
        );
    end

    // Second-level lookahead: group carries and stage carry-out from the stage's G/P.
    always_comb begin
        grp_c    = '0;
        stg_cout = '0;
        for (int k = 0; k < STAGES; k++) begin
            for (int j = 0; j < GPS; j++)
                grp_c[k*GPS+j] = la_carry(grp_g, grp_p, k*GPS, j, stg_c[k]);
            stg_cout[k] = la_carry(grp_g, grp_p, k*GPS, GPS, stg_c[k]);
        end
    end

    // Merge this stage's freshly computed bits into the running sum.
    always_comb begin
        nxt_sum = stg_sum;
        for (int g = 0; g < NG; g++) nxt_sum[g/GPS][4*g +: 4] = grp_sum[g];
    end

    // Carry into the MSB recovered from its sum bit: s = a ^ b' ^ c.
    assign c_msb = nxt_sum[STAGES-1][WIDTH-1] ^ stg_a[STAGES-1][WIDTH-1] ^ stg_b[STAGES-1][WIDTH-1];

    // Pipeline advance: all stages shift together; bubbles move but leave data untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            q_a      <= '0;
            q_b      <= '0;
            q_c      <= '0;
            q_sum    <= '0;
            q_ovf    <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_pipe[k+1] <= stg_v[k];
                if (stg_v[k]) begin
                    q_a[k]   <= stg_a[k];
                    q_b[k]   <= stg_b[k];
                    q_c[k]   <= stg_cout[k];
                    q_sum[k] <= nxt_sum[k];
                end
            end
            if (stg_v[STAGES-1]) q_ovf <= c_msb ^ stg_cout[STAGES-1];
        end
    end

    assign sum  = q_sum[STAGES-1];
    assign cout = q_c[STAGES-1];
    assign ovf  = q_ovf;
    assign neg  = sum[WIDTH-1];
    assign zero = out_valid & ~|sum;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed bench: vector table, backpressure stream, mid-flight reset on three configs.
module tb_pipelined_cla_addsub;
    import mips_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        cin = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0, b = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [63:0] a64 = '0, b64 = '0;

    logic        rdy_m, vld_m, co_m, ov_m, ng_m, z_m;
    logic [31:0] sum_m;
    logic        rdy_s, vld_s, co_s, ov_s, ng_s, z_s;
    logic [7:0]  sum_s;
    logic        rdy_l, vld_l, co_l, ov_l, ng_l, z_l;
    logic [63:0] sum_l;
    logic [35:0] res_m;
    logic [11:0] res_s;
    logic [67:0] res_l;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipelined_cla_addsub #(.WIDTH(32), .STAGES(2)) u_m (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_m), .op(op),
        .a(a), .b(b), .cin(cin), .out_valid(vld_m), .out_ready(out_ready),
        .sum(sum_m), .cout(co_m), .ovf(ov_m), .neg(ng_m), .zero(z_m));

    pipelined_cla_addsub #(.WIDTH(8), .STAGES(1)) u_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s), .op(op),
        .a(a8), .b(b8), .cin(cin), .out_valid(vld_s), .out_ready(out_ready),
        .sum(sum_s), .cout(co_s), .ovf(ov_s), .neg(ng_s), .zero(z_s));

    pipelined_cla_addsub #(.WIDTH(64), .STAGES(4)) u_l (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_l), .op(op),
        .a(a64), .b(b64), .cin(cin), .out_valid(vld_l), .out_ready(out_ready),
        .sum(sum_l), .cout(co_l), .ovf(ov_l), .neg(ng_l), .zero(z_l));

    assign res_m = {sum_m, co_m, ov_m, ng_m, z_m};
    assign res_s = {sum_s, co_s, ov_s, ng_s, z_s};
    assign res_l = {sum_l, co_l, ov_l, ng_l, z_l};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain wide integer arithmetic; returns {sum, cout, ovf, neg, zero}.
    function automatic logic [35:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic ci);
        logic [32:0] r;
        logic signed [33:0] sr;
        logic [31:0] yy;
        logic c0, v;
        yy = (o == 2'd1) ? ~y : y;
        c0 = (o == 2'd1) ? 1'b1 : ((o == 2'd2) ? ci : 1'b0);
        r  = {1'b0, x} + {1'b0, yy} + {32'd0, c0};
        sr = $signed({{2{x[31]}}, x}) + $signed({{2{yy[31]}}, yy}) + $signed({33'd0, c0});
        v  = (sr > 34'sh7FFFFFFF) || (sr < -34'sh80000000);
        return {r[31:0], r[32], v, r[31], (r[31:0] == 32'd0)};
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b;
        logic        cin;
        logic [31:0] s;
        logic        co, ov, ng, z;
    } vec_t;

    vec_t        tbl[10];
    logic [1:0]  bop[8];
    logic [31:0] ba[8], bb[8];
    logic        bc[8];
    logic [35:0] bexp[8];
    logic [35:0] hold;
    int          sent, got;
    logic        stall, acc, lv;

    initial begin
        tbl[0] = '{2'd0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{2'd0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{2'd1, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{2'd1, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{2'd2, 32'h0000FFFF, 32'h00000000, 1'b1, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{2'd1, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{2'd3, 32'h12345678, 32'h11111111, 1'b1, 32'h23456789, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{2'd1, 32'h00000003, 32'h00000005, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{2'd0, 32'h00000001, 32'h00000001, 1'b1, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_out_valid", vld_m, 1'b0);
        check("rst_outputs", res_m, 36'd0);
        check("rst_in_ready", rdy_m, 1'b1);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Directed vectors: one beat each, latency exactly 2, bubbles between beats
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            op = tbl[i].op; a = tbl[i].a; b = tbl[i].b; cin = tbl[i].cin; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check($sformatf("vec%0d_early", i), vld_m, 1'b0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid", i), vld_m, 1'b1);
            check($sformatf("vec%0d_result", i), res_m,
                  {tbl[i].s, tbl[i].co, tbl[i].ov, tbl[i].ng, tbl[i].z});
        end

        // Backpressure stream: 8 beats, out_ready low for cycles 4..6
        for (int i = 0; i < 8; i++) begin
            bop[i]  = 2'($urandom_range(0, 3));
            ba[i]   = $urandom;
            bb[i]   = $urandom;
            bc[i]   = 1'($urandom_range(0, 1));
            bexp[i] = model(bop[i], ba[i], bb[i], bc[i]);
        end
        sent = 0; got = 0; hold = '0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            stall     = (cyc >= 4 && cyc <= 6);
            out_ready = !stall;
            in_valid  = (sent < 8);
            if (sent < 8) begin
                op = bop[sent]; a = ba[sent]; b = bb[sent]; cin = bc[sent];
            end
            @(negedge clk);
            if (stall) begin
                check("bp_in_ready_low", rdy_m, 1'b0);
                if (cyc == 4) begin
                    check("bp_stall_valid", vld_m, 1'b1);
                    hold = res_m;
                end else begin
                    check("bp_stable", res_m, hold);
                end
            end
            acc = in_valid && rdy_m;
            lv  = vld_m && out_ready;
            if (lv) begin
                if (got < 8) check($sformatf("bp_beat%0d", got), res_m, bexp[got]);
                else check("bp_extra_beat", got, 8);
                got++;
            end
            if (acc) sent++;
            @(posedge clk); #1;
        end
        check("bp_count", got, 8);
        in_valid = 1'b0; out_ready = 1'b1;

        // Reset with beats in flight on all three configurations
        @(posedge clk); #1;
        op = 2'd0; in_valid = 1'b1;
        a = 32'h11; b = 32'h22; a8 = 8'h11; b8 = 8'h22; a64 = 64'h11; b64 = 64'h22;
        @(posedge clk); #1;
        a = 32'h33; a8 = 8'h33; a64 = 64'h33;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mrst_valid_32", vld_m, 1'b0);
        check("mrst_out_32", res_m, 36'd0);
        check("mrst_valid_8", vld_s, 1'b0);
        check("mrst_out_8", res_s, 12'd0);
        check("mrst_valid_64", vld_l, 1'b0);
        check("mrst_out_64", res_l, 68'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; op = 2'd0; cin = 1'b0;
        a = 32'h0000FFFF; b = 32'h1;
        a8 = 8'h7F; b8 = 8'h01;
        a64 = 64'hFFFFFFFF_FFFFFFFF; b64 = 64'h1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            check($sformatf("post_rst_v32_e%0d", e), vld_m, (e == 2));
            check($sformatf("post_rst_v8_e%0d", e),  vld_s, (e == 1));
            check($sformatf("post_rst_v64_e%0d", e), vld_l, (e == 4));
            if (e == 2) check("post_rst_res32", res_m, {32'h00010000, 4'b0000});
            if (e == 1) check("post_rst_res8", res_s, {8'h80, 4'b0110});
            if (e == 4) check("post_rst_res64", res_l, {64'h0, 4'b1001});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_addsub.md
# pipelined_cla_addsub

Parametrised, pipelined carry-lookahead adder/subtractor for the MIPS datapath ALU and multi-cycle arithmetic units. It builds on the 4-bit generate/propagate carry-lookahead scheme and extends it in three ways: operand width `WIDTH`, a configurable number of register stages `STAGES`, and an add/subtract/add-with-carry mode. It produces sum, carry and N/Z/V flags behind a valid/ready handshake with full backpressure.

## Interface
- `WIDTH`, 32: operand width; must be a multiple of 4 and at least 4.
- `STAGES`, 2: pipeline register stages; must be at least 1 and divide `WIDTH/4`.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block accepts beat this cycle.
- `op`  in  2  operation select: `OP_ADD`, `OP_SUB`, `OP_ADDC` (value 3 is treated as `OP_ADD`).
- `a`, `b`  in  `WIDTH`  operands.
- `cin`  in  1  carry-in; used only by `OP_ADDC`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `sum`  out  `WIDTH`  result.
- `cout`  out  1  carry out of the MSB. For SUB, 1 means no borrow.
- `ovf`  out  1  signed overflow.
- `neg`  out  1  equals `sum[WIDTH-1]`.
- `zero`  out  1  high when `sum == 0`.

## Operation
- **Operand setup at stage 0:**
  - `OP_SUB`: `b' = ~b`, carry-in = 1.
  - `OP_ADD`: `b' = b`, carry-in = 0.
  - `OP_ADDC`: `b' = b`, carry-in = `cin`.
- **Group generate/propagate:** `G = WIDTH/4` groups. Per bit, `g = a & b'` and `p = a ^ b'`. Each 4-bit group computes its internal carries by lookahead and exports a group generate and propagate.
- **Stage split:** stage k handles groups `[k*G/STAGES, (k+1)*G/STAGES)`. Within a stage, group carries use second-level lookahead across the stage's groups.
- **Carry between stages:** stage k's carry-out is registered and becomes stage k+1's carry-in.
- **Pipeline registers:** each register carries the completed low sum bits, the unconsumed high `a`/`b'` bits, the running carry and a valid bit.
- **Final stage outputs:**
  - `cout` is the carry out of bit `WIDTH-1`.
  - `ovf` is the carry into bit `WIDTH-1` XOR the carry out of it.
  - `neg` and `zero` are derived from the registered sum.
- **Advance:** `adv = out_ready | ~out_valid`, and `in_ready = adv`.
  - All stages shift together when `adv` is high.
  - Bubbles (invalid slots) shift through; they are not collapsed.
  - A beat is accepted when `in_valid & in_ready`. A beat leaves when `out_valid & out_ready`.
  - Accept and leave in the same cycle is legal and loses no data.
- **Stall:** when `adv` is low, every register holds. Output data stays stable while `out_valid` is high and `out_ready` is low.
- **Reset:** asserting `rst_n` low at any time clears all valid bits, all data registers and all outputs to 0, including `zero`, which is forced to 0 while `out_valid` is 0. In-flight beats are discarded and never emitted.
- **Idle outputs:** when `out_valid` is 0, `sum`, `cout`, `ovf` and `neg` hold their last values. Consumers ignore them.

## Timing
- **Latency:** exactly `STAGES` cycles from acceptance to `out_valid` when not stalled.
- **Throughput:** one beat per cycle when `out_ready` is held high.
- **Combinational paths:** `in_ready` depends combinationally on `out_ready`. There is no combinational path from `a`, `b`, `op` or `cin` to any output.
- **Critical path:** one stage of `WIDTH/STAGES` bits of two-level lookahead.
- **Reset release:** first acceptance is possible in the first cycle after `rst_n` deasserts.

## Structure
- **Shared package `mips_alu_pkg`:** the `op` encodings `OP_ADD=0`, `OP_SUB=1`, `OP_ADDC=2`, and the `alu_op_t` typedef.
- **Sub-module `cla_group4`:** inputs a, b', carry-in; outputs 4-bit sum, group G, group P. Instantiate it `WIDTH/4` times via generate.
- **Top level:** contains the stage loop, the pipeline registers and the handshake.
- **Elaboration check:** a parameter assertion fails elaboration if `WIDTH%4 != 0` or `(WIDTH/4)%STAGES != 0`.

## Test plan
All scenarios use `WIDTH=32`, `STAGES=2` unless stated.
- **Signed overflow:** ADD `0x7FFFFFFF + 0x00000001` → after 2 cycles `sum=0x80000000`, `ovf=1`, `neg=1`, `cout=0`, `zero=0`.
- **Unsigned wrap:** ADD `0xFFFFFFFF + 0x00000001` → `sum=0`, `cout=1`, `zero=1`, `ovf=0`.
- **Subtract:**
  - SUB `5 - 5` → `sum=0`, `zero=1`, `cout=1`.
  - SUB `0 - 1` → `sum=0xFFFFFFFF`, `cout=0`, `neg=1`, `ovf=0`.
- **Add with carry:** ADDC `0x0000FFFF + 0x00000000` with `cin=1` → `sum=0x00010000`. This also crosses the stage boundary at bit 15/16 and checks carry propagation between stages.
- **Backpressure:** stream 8 random beats; hold `out_ready=0` for 3 cycles mid-stream.
  - `in_ready` drops in the same cycles.
  - Outputs stay stable while stalled.
  - All 8 results arrive in order against a reference model, with no loss or duplication.
- **Reset mid-operation:** assert `rst_n` low with 2 beats in flight.
  - `out_valid=0` immediately, all outputs 0.
  - After release, no stale results appear.
  - A new beat completes in 2 cycles.
  - Repeat with `WIDTH=8`, `STAGES=1` and `WIDTH=64`, `STAGES=4`.
